// File: rtl/i2c_pkg.sv
// Shared types and default parameters for the I2C bus front end.
package i2c_pkg;

    localparam int unsigned DEF_SYNC_STAGES    = 2;
    localparam int unsigned DEF_FILTER_LEN     = 3;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_t;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Per-line synchronizer plus persistence filter; idles at the bus high level.
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned FILTER_LEN  = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt,
    output logic toggle_c
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("i2c_glitch_filter: SYNC_STAGES must be at least 2");
    end
    if (FILTER_LEN < 1) begin : g_bad_filter
        $error("i2c_glitch_filter: FILTER_LEN must be at least 1");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Filtered level flips on the edge where the counter would reach FILTER_LEN.
    assign toggle_c = (synced != filt) && (cnt == CW'(FILTER_LEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            filt   <= 1'b1;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (toggle_c) begin
                filt <= ~filt;
                cnt  <= '0;
            end else if (synced != filt) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/i2c_bus_frontend.sv
// I2C line conditioning, edge/START/STOP detection and bus-busy tracking.
// Optional SCL-stuck-low timeout enabled by defining I2C_FRONTEND_TIMEOUT_EN.
module i2c_bus_frontend
    import i2c_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_filt,
    output logic sda_filt,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic bus_busy,
    output logic timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("i2c_bus_frontend: TIMEOUT_CYCLES must be at least 1");
    end

    logic       scl_toggle_c;
    logic       sda_toggle_c;
    logic       start_c;
    logic       stop_c;
    bus_state_t state;

    i2c_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_scl_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw     (scl_in),
        .filt    (scl_filt),
        .toggle_c(scl_toggle_c)
    );

    i2c_glitch_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN)
    ) u_sda_filter (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw     (sda_in),
        .filt    (sda_filt),
        .toggle_c(sda_toggle_c)
    );

    // Qualify SDA transitions with a steady-high SCL; registered so pulses align with the new level.
    assign start_c = sda_toggle_c &&  sda_filt && scl_filt && !scl_toggle_c;
    assign stop_c  = sda_toggle_c && !sda_filt && scl_filt && !scl_toggle_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
        end else begin
            scl_rise  <= scl_toggle_c && !scl_filt;
            scl_fall  <= scl_toggle_c &&  scl_filt;
            start_det <= start_c;
            stop_det  <= stop_c;
        end
    end

    // Bus state follows the registered detector pulses, so busy lags start/stop by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            bus_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state    <= BUSY;
                        bus_busy <= 1'b1;
                    end
                end
                BUSY: begin
                    if (stop_det || timeout) begin
                        state    <= IDLE;
                        bus_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef I2C_FRONTEND_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;

    // Counts consecutive filtered-SCL-low cycles while the bus is owned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= 1'b0;
            if ((state == IDLE) || scl_filt) begin
                to_cnt <= '0;
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                to_cnt  <= '0;
                timeout <= 1'b1;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Directed self-checking bench for i2c_bus_frontend (SYNC_STAGES=2, FILTER_LEN=3, TIMEOUT_CYCLES=16).
module tb_i2c_bus_frontend;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic scl_in = 1'b1;
    logic sda_in = 1'b1;

    logic scl_filt, sda_filt, scl_rise, scl_fall;
    logic start_det, stop_det, bus_busy, timeout;

    int errors = 0;
    int checks = 0;
    int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0, n_to = 0;
    int base, base_a, base_b;

    always #5 clk = ~clk;

    i2c_bus_frontend #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (3),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_in   (scl_in),
        .sda_in   (sda_in),
        .scl_filt (scl_filt),
        .sda_filt (sda_filt),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start_det(start_det),
        .stop_det (stop_det),
        .bus_busy (bus_busy),
        .timeout  (timeout)
    );

    // Pulse tallies sampled mid-cycle.
    always @(negedge clk) begin
        if (scl_rise === 1'b1)  n_rise  += 1;
        if (scl_fall === 1'b1)  n_fall  += 1;
        if (start_det === 1'b1) n_start += 1;
        if (stop_det === 1'b1)  n_stop  += 1;
        if (timeout === 1'b1)   n_to    += 1;
    end

    function automatic int pulses();
        return n_rise + n_fall + n_start + n_stop + n_to;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset with idle bus
        #2 rst_n = 1'b0;
        tick(3);
        chk("rst_scl_filt",  32'(scl_filt),  1);
        chk("rst_sda_filt",  32'(sda_filt),  1);
        chk("rst_bus_busy",  32'(bus_busy),  0);
        chk("rst_scl_rise",  32'(scl_rise),  0);
        chk("rst_scl_fall",  32'(scl_fall),  0);
        chk("rst_start_det", 32'(start_det), 0);
        chk("rst_stop_det",  32'(stop_det),  0);
        chk("rst_timeout",   32'(timeout),   0);

        rst_n = 1'b1;
        base = pulses();
        tick(20);
        chk("idle_no_pulses", 32'(pulses() - base), 0);
        chk("idle_scl_filt",  32'(scl_filt), 1);
        chk("idle_busy",      32'(bus_busy), 0);

        // START: sda falls with scl high; filtered on the 5th edge
        sda_in = 1'b0;
        tick(4);
        chk("start_sda_not_yet", 32'(sda_filt), 1);
        tick(1);
        chk("start_sda_filt", 32'(sda_filt),  0);
        chk("start_det_hi",   32'(start_det), 1);
        chk("start_busy_lag", 32'(bus_busy),  0);
        tick(1);
        chk("start_det_lo",   32'(start_det), 0);
        chk("start_busy_hi",  32'(bus_busy),  1);

        // 2-cycle SCL glitch is rejected
        base = n_fall;
        scl_in = 1'b0;
        tick(2);
        scl_in = 1'b1;
        tick(10);
        chk("glitch2_no_fall", 32'(n_fall - base), 0);
        chk("glitch2_scl",     32'(scl_filt), 1);

        // 3-cycle SCL low is accepted: one fall, one rise
        base_a = n_fall;
        base_b = n_rise;
        scl_in = 1'b0;
        tick(3);
        scl_in = 1'b1;
        tick(2);
        chk("low3_scl_filt", 32'(scl_filt), 0);
        chk("low3_fall_hi",  32'(scl_fall), 1);
        tick(1);
        chk("low3_fall_lo",  32'(scl_fall), 0);
        tick(2);
        chk("low3_scl_back", 32'(scl_filt), 1);
        chk("low3_rise_hi",  32'(scl_rise), 1);
        tick(1);
        chk("low3_rise_lo",  32'(scl_rise), 0);
        tick(5);
        chk("low3_fall_cnt", 32'(n_fall - base_a), 1);
        chk("low3_rise_cnt", 32'(n_rise - base_b), 1);

        // STOP while busy
        sda_in = 1'b1;
        tick(4);
        chk("stop_not_yet",   32'(stop_det), 0);
        tick(1);
        chk("stop_det_hi",    32'(stop_det), 1);
        chk("stop_busy_hold", 32'(bus_busy), 1);
        tick(1);
        chk("stop_det_lo",    32'(stop_det), 0);
        chk("stop_busy_lo",   32'(bus_busy), 0);

        // SCL and SDA fall together: edge pulse only, no START
        base = n_start;
        scl_in = 1'b0;
        sda_in = 1'b0;
        tick(5);
        chk("simul_scl_fall", 32'(scl_fall),  1);
        chk("simul_no_start", 32'(start_det), 0);
        chk("simul_sda_filt", 32'(sda_filt),  0);
        tick(10);
        chk("simul_start_cnt", 32'(n_start - base), 0);
        chk("simul_busy",      32'(bus_busy), 0);

        // STOP in IDLE: pulse without state change
        scl_in = 1'b1;
        tick(10);
        chk("idle_stop_scl_up", 32'(scl_filt), 1);
        sda_in = 1'b1;
        tick(5);
        chk("idle_stop_det", 32'(stop_det), 1);
        chk("idle_stop_busy", 32'(bus_busy), 0);
        tick(1);
        chk("idle_stop_lo",  32'(stop_det), 0);
        chk("idle_stop_busy2", 32'(bus_busy), 0);
        chk("idle_stop_no_start", 32'(n_start - base), 0);

        // Repeated START keeps the bus busy
        sda_in = 1'b0;
        tick(6);
        chk("rs_first_busy", 32'(bus_busy), 1);
        scl_in = 1'b0;
        tick(8);
        sda_in = 1'b1;
        tick(8);
        scl_in = 1'b1;
        tick(8);
        base = n_stop;
        sda_in = 1'b0;
        tick(5);
        chk("rs_start_det", 32'(start_det), 1);
        chk("rs_busy",      32'(bus_busy),  1);
        tick(1);
        chk("rs_start_lo",  32'(start_det), 0);
        chk("rs_busy_hold", 32'(bus_busy),  1);
        chk("rs_no_stop",   32'(n_stop - base), 0);

        // Asynchronous reset mid-transaction with SCL low
        scl_in = 1'b0;
        tick(8);
        chk("mid_scl_low", 32'(scl_filt), 0);
        chk("mid_busy",    32'(bus_busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_scl_filt", 32'(scl_filt), 1);
        chk("arst_sda_filt", 32'(sda_filt), 1);
        chk("arst_busy",     32'(bus_busy), 0);
        chk("arst_pulses",   32'({scl_rise, scl_fall, start_det, stop_det, timeout}), 0);
        scl_in = 1'b1;
        sda_in = 1'b1;
        tick(3);
        rst_n = 1'b1;
        base = pulses();
        tick(20);
        chk("rel_no_pulses", 32'(pulses() - base), 0);
        chk("rel_busy",      32'(bus_busy), 0);

        // SCL stuck low while busy
        sda_in = 1'b0;
        tick(6);
        chk("to_busy_start", 32'(bus_busy), 1);
        base = n_to;
        scl_in = 1'b0;
        tick(20);
        chk("to_not_yet",  32'(timeout),  0);
        chk("to_busy_pre", 32'(bus_busy), 1);
        tick(1);
`ifdef I2C_FRONTEND_TIMEOUT_EN
        chk("to_pulse_hi", 32'(timeout),  1);
        chk("to_busy_hi",  32'(bus_busy), 1);
        tick(1);
        chk("to_pulse_lo", 32'(timeout),  0);
        chk("to_busy_lo",  32'(bus_busy), 0);
        tick(20);
        chk("to_count",    32'(n_to - base), 1);
`else
        chk("to_off_lo",   32'(timeout),  0);
        chk("to_off_busy", 32'(bus_busy), 1);
        tick(20);
        chk("to_off_busy2", 32'(bus_busy), 1);
        chk("to_off_count", 32'(n_to - base), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_bus_frontend.md
I2C_BUS_FRONTEND -- requirements
Module: i2c_bus_frontend

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchronizer flop depth per line, minimum 2.
REQ-002 SHALL have parameter FILTER_LEN, default 3: consecutive cycles a new level must persist before it is accepted, minimum 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: SCL-low cycles in BUSY before timeout; used only when the macro in REQ-020 is defined.
REQ-004 SHALL have ports:
- clk  in  1  system clock; the single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- scl_in  in  1  raw SCL pad input, asynchronous to clk.
- sda_in  in  1  raw SDA pad input, asynchronous to clk.
- scl_filt  out  1  synchronized, filtered SCL.
- sda_filt  out  1  synchronized, filtered SDA.
- scl_rise  out  1  one-cycle pulse on a scl_filt 0->1 transition.
- scl_fall  out  1  one-cycle pulse on a scl_filt 1->0 transition.
- start_det  out  1  one-cycle pulse on START or repeated START.
- stop_det  out  1  one-cycle pulse on STOP.
- bus_busy  out  1  high between START and STOP/timeout.
- timeout  out  1  one-cycle pulse on bus-stuck timeout; tied 0 when the feature is compiled out.

Function
REQ-005 SHALL pass each raw input through SYNC_STAGES flops before any other logic.
REQ-006 SHALL run one counter per line: increment while synced != filtered, clear to 0 when equal; when the counter reaches FILTER_LEN, the filtered level SHALL toggle and the counter SHALL clear on the same edge.
REQ-007 SHALL make a stable raw input change visible on *_filt exactly SYNC_STAGES+FILTER_LEN clk edges after the first sampling edge.
REQ-008 SHALL ignore a pulse that is shorter than FILTER_LEN cycles after synchronization; the filtered level SHALL stay unchanged.
REQ-009 SHALL assert scl_rise/scl_fall only during the first cycle in which scl_filt shows the new level.
REQ-010 SHALL detect START as sda_filt 1->0 while scl_filt is 1 and unchanged in that cycle; STOP as sda_filt 0->1 under the same condition.
REQ-011 SHALL NOT report START or STOP when scl_filt and sda_filt change in the same cycle; scl_rise/scl_fall SHALL still pulse.
REQ-012 SHALL implement a 2-state FSM, IDLE/BUSY: IDLE->BUSY on START; BUSY->IDLE on STOP or timeout; START in BUSY (repeated START) SHALL pulse start_det and stay in BUSY.
REQ-013 SHALL make bus_busy a registered output, high from the cycle after start_det through the cycle of stop_det/timeout; it SHALL be low the cycle after.
REQ-014 SHALL pulse stop_det while in IDLE without a state change.
REQ-015 SHALL give start_det, stop_det and timeout a width of exactly one cycle each, with no back-to-back repeats from a single bus event.

Reset
REQ-016 SHALL asynchronously force every synchronizer flop and scl_filt/sda_filt to 1, the bus idle level.
REQ-017 SHALL clear all counters, set FSM=IDLE, and drive bus_busy, scl_rise, scl_fall, start_det, stop_det and timeout to 0.
REQ-018 SHALL abandon any transaction in progress when reset asserts; no pulse SHALL be emitted on release.
REQ-019 SHALL produce no spurious START/STOP on release while the inputs are high.

Configuration
REQ-020 With macro I2C_FRONTEND_TIMEOUT_EN defined, SHALL count consecutive cycles of scl_filt==0 in BUSY, using a counter sized to hold TIMEOUT_CYCLES; on reaching TIMEOUT_CYCLES it SHALL pulse timeout, go to IDLE and clear the counter.
REQ-021 The timeout counter SHALL clear whenever scl_filt==1 or the FSM is in IDLE.
REQ-022 Without I2C_FRONTEND_TIMEOUT_EN, SHALL contain no timeout counter, tie timeout to 0, and make BUSY exit only on STOP.

Structure
REQ-023 SHALL place the FSM state enum (IDLE, BUSY) and the default SYNC_STAGES/FILTER_LEN/TIMEOUT_CYCLES constants in shared package i2c_pkg.
REQ-024 SHALL implement the per-line synchronizer+filter as sub-module i2c_glitch_filter, instantiated once for SCL and once for SDA.

Verification (defaults; TIMEOUT_CYCLES=16 for timeout)
REQ-025 Reset asserted then released with scl_in=sda_in=1 -> scl_filt=1, sda_filt=1, bus_busy=0, no pulses for 20 cycles.
REQ-026 sda_in 1->0 with scl_in=1 held -> sda_filt falls 5 edges later; start_det one cycle in that cycle; bus_busy=1 next cycle.
REQ-027 2-cycle low glitch on scl_in -> scl_filt stays 1, no scl_fall; 3-cycle low -> exactly one scl_fall and one scl_rise.
REQ-028 scl_in and sda_in fall on the same clk edge -> scl_fall pulses, no start_det; sda_in 0->1 with scl high in BUSY -> stop_det, bus_busy=0.
REQ-029 Reset mid-BUSY, scl low -> all outputs at reset values immediately; on release no pulse, FSM=IDLE.
REQ-030 With the macro: START, then scl_in held low 16 filtered cycles -> timeout one cycle, bus_busy=0; without the macro, same stimulus -> timeout stays 0 and bus_busy stays 1.
